jtkiwi_shram_arb: RTL and testbench
===================================

# jtkiwi_shram_arb

Two-port arbiter that shares the single-port 8 kB shared RAM between the main CPU and the sub/sound CPU in the Kiwi core. It serialises requests with round-robin fairness and drives the RAM's address, write-data and write-enable lines. It returns read data and a one-cycle `ok` pulse per access. It also provides a `wait` level that each CPU wrapper uses to stretch its bus cycle.

## Interface
Parameters:
- `AW`, 13, address width (8 kB RAM)
- `DW`, 8, data width

Ports:
- `clk` in 1: system clock (24 MHz domain); single clock for the whole block
- `rst` in 1: asynchronous, active-high reset
- `main_cs` in 1: main CPU request level; held high until `main_ok`
- `main_we` in 1: 1 = write, 0 = read; sampled at grant
- `main_addr` in AW: address; sampled at grant
- `main_din` in DW: write data; sampled at grant
- `main_dout` out DW: read data; valid from the `main_ok` cycle; held until the next main read completes
- `main_ok` out 1: one-cycle completion pulse
- `main_wait` out 1: combinational; `main_cs & ~main_served & ~main_ok`
- `sub_cs`, `sub_we`, `sub_addr`, `sub_din`, `sub_dout`, `sub_ok`, `sub_wait`: same as the main port, for the sub CPU
- `ram_addr` out AW: RAM address (registered)
- `ram_din` out DW: RAM write data (registered)
- `ram_we` out 1: RAM write strobe; one cycle per write access
- `ram_dout` in DW: RAM read data; synchronous, valid one cycle after `ram_addr`

## Operation
- The FSM has four states: IDLE, ACC, LAT, ACK.
- **Eligibility:** port X is pending when `X_cs & ~X_served`.
  - `X_served` is set on the clock edge ending X's ACK cycle, if `X_cs` is still high.
  - `X_served` clears when `X_cs` is low.
  - A held-high `cs` therefore generates exactly one access.
- **IDLE:**
  - If only one port is pending, grant it.
  - If both are pending, grant the port ≠ `last`; `last` then becomes the granted port.
  - On grant, capture addr/we/din into `ram_addr`/`ram_din`, set `ram_we = we`, then go to ACC.
- **ACC:** RAM is addressed. `ram_we` is high only in this cycle, and only for writes. Next state is LAT.
- **LAT:** `ram_dout` is valid. For reads, capture it into the granted port's `dout` register. Next state is ACK.
- **ACK:** the granted port's `ok` is high for this cycle only. Next state is IDLE.
- **Writes** do not modify `X_dout`.
- **Granted access always completes,** even if `X_cs` drops mid-access.
  - The write is still performed and `ok` still pulses.
  - `served` is not set, because `cs` is low.
- Input changes after the grant are ignored until the next grant.
- **Reset values:**
  - state IDLE, `last` = sub (main wins the first tie)
  - `served` flags 0
  - `ram_addr`/`ram_din` 0, `ram_we` 0
  - `main_dout`/`sub_dout` 0, `main_ok`/`sub_ok` 0
- Asserting `rst` mid-access aborts it immediately. No `ok` is issued, and `ram_we` drops asynchronously.

## Timing
- **Unloaded latency:** `cs` rises before edge 0 → grant at edge 0 → ACC in cycle 1 → LAT in cycle 2 → ACK in cycle 3 (`ok` high, `dout` valid).
- **Throughput:** one access per 4 cycles; IDLE lasts at least 1 cycle between accesses.
- **Worst-case wait** for a pending port while the other is being served: the remainder of the current access plus 4 cycles. Round-robin guarantees no starvation.
- **Simultaneous `cs` rise:** the non-`last` port is served first; the other port is granted in the IDLE immediately after ACK, so its `ok` comes 4 cycles later.
- **`main_wait`/`sub_wait`:** high from `cs` rise until the `ok` cycle inclusive-exclusive; low during `ok` and while `served` is set.
- `ram_we` is never high for more than one consecutive cycle, and only in ACC.

## Test plan
- **Single main read:** preload RAM[0x0123] = 0x5A; `main_cs`=1, `we`=0, addr 0x0123 → `main_ok` exactly 3 cycles after grant edge, `main_dout` = 0x5A, `main_wait` low from the `ok` cycle, no second access while `cs` stays high.
- **Sub write then main read:** sub writes 0xC3 to 0x1FFF, then main reads 0x1FFF → `ram_we` pulses 1 cycle with `ram_addr` 0x1FFF, `ram_din` 0xC3; main reads 0xC3; `sub_dout` unchanged.
- **Simultaneous requests after reset:** both `cs` rise on the same cycle → main `ok` at cycle 3, sub `ok` at cycle 7; repeat with both → sub served first this time (alternation).
- **Continuous contention:** both ports re-request immediately after each `ok` for 100 accesses → grants alternate strictly, each port gets 50, and no `ok` is lost.
- **`cs` dropped mid-access:** main write granted, `main_cs` low in ACC → write still lands, `main_ok` pulses, `main_served` stays 0; a new `cs` rise starts a fresh access.
- **Reset during LAT:** assert `rst` → `ram_we`, `ok`, `dout` go to 0 immediately and state returns to IDLE; after release, a pending main request completes normally in 3 cycles.

Source files
------------

// File: rtl/jtkiwi_shram_arb_if.sv
// Shared-RAM arbiter bus: two CPU request ports plus the single-port RAM side.
interface jtkiwi_shram_arb_if #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
);
  logic          main_cs;
  logic          main_we;
  logic [AW-1:0] main_addr;
  logic [DW-1:0] main_din;
  logic [DW-1:0] main_dout;
  logic          main_ok;
  logic          main_wait;

  logic          sub_cs;
  logic          sub_we;
  logic [AW-1:0] sub_addr;
  logic [DW-1:0] sub_din;
  logic [DW-1:0] sub_dout;
  logic          sub_ok;
  logic          sub_wait;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  main_cs, main_we, main_addr, main_din,
    output main_dout, main_ok, main_wait,
    input  sub_cs, sub_we, sub_addr, sub_din,
    output sub_dout, sub_ok, sub_wait,
    output ram_addr, ram_din, ram_we,
    input  ram_dout
  );

  modport master (
    output main_cs, main_we, main_addr, main_din,
    input  main_dout, main_ok, main_wait,
    output sub_cs, sub_we, sub_addr, sub_din,
    input  sub_dout, sub_ok, sub_wait,
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/jtkiwi_shram_arb.sv
// Round-robin arbiter sharing the single-port 8 kB RAM between main and sub CPUs.
// Each access takes IDLE -> ACC -> LAT -> ACK; a held-high cs yields exactly one access.
module jtkiwi_shram_arb #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  jtkiwi_shram_arb_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] LAT  = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;

  localparam logic PORT_MAIN = 1'b0;
  localparam logic PORT_SUB  = 1'b1;

  logic [1:0]    state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          last, last_nxt;
  logic          req_we, req_we_nxt;
  logic          main_served, main_served_nxt;
  logic          sub_served, sub_served_nxt;
  logic [AW-1:0] ram_addr, ram_addr_nxt;
  logic [DW-1:0] ram_din, ram_din_nxt;
  logic          ram_we, ram_we_nxt;
  logic [DW-1:0] main_dout, main_dout_nxt;
  logic [DW-1:0] sub_dout, sub_dout_nxt;
  logic          main_ok, main_ok_nxt;
  logic          sub_ok, sub_ok_nxt;
  logic          main_pend, sub_pend, grant_sub;

  // Next-state, grant decision and registered-output staging
  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    last_nxt      = last;
    req_we_nxt    = req_we;
    ram_addr_nxt  = ram_addr;
    ram_din_nxt   = ram_din;
    ram_we_nxt    = 1'b0;
    main_dout_nxt = main_dout;
    sub_dout_nxt  = sub_dout;
    main_ok_nxt   = 1'b0;
    sub_ok_nxt    = 1'b0;
    grant_sub     = 1'b0;

    main_pend = bus.main_cs & ~main_served;
    sub_pend  = bus.sub_cs  & ~sub_served;

    // served latches at the end of the port's own ACK and only survives while cs stays high
    main_served_nxt = bus.main_cs & (main_served | ((state == ACK) && (gnt == PORT_MAIN)));
    sub_served_nxt  = bus.sub_cs  & (sub_served  | ((state == ACK) && (gnt == PORT_SUB)));

    case (state)
      IDLE: begin
        if (main_pend | sub_pend) begin
          grant_sub = sub_pend & (~main_pend | (last == PORT_MAIN));
          if (main_pend & sub_pend) last_nxt = grant_sub;
          gnt_nxt      = grant_sub;
          req_we_nxt   = grant_sub ? bus.sub_we   : bus.main_we;
          ram_addr_nxt = grant_sub ? bus.sub_addr : bus.main_addr;
          ram_din_nxt  = grant_sub ? bus.sub_din  : bus.main_din;
          ram_we_nxt   = grant_sub ? bus.sub_we   : bus.main_we;
          state_nxt    = ACC;
        end
      end
      ACC: state_nxt = LAT;
      LAT: begin
        if (!req_we) begin
          if (gnt == PORT_SUB) sub_dout_nxt  = bus.ram_dout;
          else                 main_dout_nxt = bus.ram_dout;
        end
        if (gnt == PORT_SUB) sub_ok_nxt  = 1'b1;
        else                 main_ok_nxt = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= PORT_MAIN;
      last        <= PORT_SUB;
      req_we      <= 1'b0;
      main_served <= 1'b0;
      sub_served  <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      main_dout   <= '0;
      sub_dout    <= '0;
      main_ok     <= 1'b0;
      sub_ok      <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last        <= last_nxt;
      req_we      <= req_we_nxt;
      main_served <= main_served_nxt;
      sub_served  <= sub_served_nxt;
      ram_addr    <= ram_addr_nxt;
      ram_din     <= ram_din_nxt;
      ram_we      <= ram_we_nxt;
      main_dout   <= main_dout_nxt;
      sub_dout    <= sub_dout_nxt;
      main_ok     <= main_ok_nxt;
      sub_ok      <= sub_ok_nxt;
    end
  end

  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;
  assign bus.ram_we    = ram_we;
  assign bus.main_dout = main_dout;
  assign bus.sub_dout  = sub_dout;
  assign bus.main_ok   = main_ok;
  assign bus.sub_ok    = sub_ok;
  assign bus.main_wait = bus.main_cs & ~main_served & ~main_ok;
  assign bus.sub_wait  = bus.sub_cs  & ~sub_served  & ~sub_ok;
endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Bench for jtkiwi_shram_arb: directed timing checks plus randomized two-CPU traffic
// compared every cycle against an access-level model with its own RAM image.
module tb_jtkiwi_shram_arb;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtkiwi_shram_arb_if #(.AW(AW), .DW(DW)) bus ();
  jtkiwi_shram_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 13'h0123) return 8'h5A;
    return DW'(a[7:0] ^ a[12:5]);
  endfunction

  // Synchronous single-port RAM driven by the DUT
  logic [DW-1:0] mem [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = init_val(AW'(i));
    forever begin
      @(posedge clk);
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Access-level model: one access in flight, tracked by its age in cycles since grant
  logic [DW-1:0] ref_mem [2**AW];
  int            m_age    = 0;
  logic          m_port   = 1'b0;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_din    = '0;
  logic [1:0]    m_served = 2'b00;
  logic          m_last   = 1'b1;
  logic [1:0]    e_ok     = 2'b00;
  logic [DW-1:0] e_dout [2] = '{8'h00, 8'h00};
  logic          e_we     = 1'b0;
  logic [AW-1:0] e_addr   = '0;
  logic [DW-1:0] e_din    = '0;

  initial begin
    logic [1:0] cs, pend, nsv;
    logic       port;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(AW'(i));
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_age = 0; m_last = 1'b1; m_served = 2'b00; e_ok = 2'b00;
        e_dout[0] = '0; e_dout[1] = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
      end else begin
        cs     = {bus.sub_cs, bus.main_cs};
        nsv[0] = cs[0] & (m_served[0] | (m_age == 3 && m_port == 1'b0));
        nsv[1] = cs[1] & (m_served[1] | (m_age == 3 && m_port == 1'b1));
        e_we   = 1'b0;
        e_ok   = 2'b00;
        if (m_age == 0) begin
          pend = cs & ~m_served;
          if (pend != 2'b00) begin
            if (pend == 2'b11) begin
              port   = ~m_last;
              m_last = port;
            end else begin
              port = pend[1];
            end
            m_port = port;
            m_we   = port ? bus.sub_we   : bus.main_we;
            m_addr = port ? bus.sub_addr : bus.main_addr;
            m_din  = port ? bus.sub_din  : bus.main_din;
            e_we = m_we; e_addr = m_addr; e_din = m_din;
            if (m_we) ref_mem[m_addr] = m_din;
            m_age = 1;
          end
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (m_age == 2) begin
          if (!m_we) e_dout[m_port] = ref_mem[m_addr];
          e_ok[m_port] = 1'b1;
          m_age = 3;
        end else begin
          m_age = 0;
        end
        m_served = nsv;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("ram_we",    32'(bus.ram_we),    32'(e_we));
      chk("ram_addr",  32'(bus.ram_addr),  32'(e_addr));
      chk("ram_din",   32'(bus.ram_din),   32'(e_din));
      chk("main_ok",   32'(bus.main_ok),   32'(e_ok[0]));
      chk("sub_ok",    32'(bus.sub_ok),    32'(e_ok[1]));
      chk("main_dout", 32'(bus.main_dout), 32'(e_dout[0]));
      chk("sub_dout",  32'(bus.sub_dout),  32'(e_dout[1]));
      chk("main_wait", 32'(bus.main_wait), 32'(bus.main_cs & ~m_served[0] & ~e_ok[0]));
      chk("sub_wait",  32'(bus.sub_wait),  32'(bus.sub_cs  & ~m_served[1] & ~e_ok[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      bus.sub_cs = 1'b1; bus.sub_we = we; bus.sub_addr = a; bus.sub_din = d;
    end else begin
      bus.main_cs = 1'b1; bus.main_we = we; bus.main_addr = a; bus.main_din = d;
    end
  endtask

  task automatic scramble(input logic p);
    if (p) begin
      bus.sub_we = 1'($urandom_range(0, 1)); bus.sub_addr = rand_addr(); bus.sub_din = DW'($urandom);
    end else begin
      bus.main_we = 1'($urandom_range(0, 1)); bus.main_addr = rand_addr(); bus.main_din = DW'($urandom);
    end
  endtask

  task automatic drop(input logic p);
    if (p) bus.sub_cs = 1'b0;
    else   bus.main_cs = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) a = a | 13'h1FF0;
    return a;
  endfunction

  initial begin
    int n_main, n_sub, prev, breaks, okc;
    logic okp, csp;
    logic [1:0] done;

    rst = 1'b1;
    bus.main_cs = 1'b0; bus.main_we = 1'b0; bus.main_addr = '0; bus.main_din = '0;
    bus.sub_cs  = 1'b0; bus.sub_we  = 1'b0; bus.sub_addr  = '0; bus.sub_din  = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
    chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
    chk("rst_main_dout", 32'(bus.main_dout), 32'd0);
    chk("rst_sub_ok",    32'(bus.sub_ok),    32'd0);
    tick();

    // Simultaneous requests: main first after reset, then sub first
    req(1'b0, 1'b0, 13'h0010, 8'h00);
    req(1'b1, 1'b0, 13'h0020, 8'h00);
    repeat (2) tick();
    chk("sim1_main_ok_early", 32'(bus.main_ok), 32'd0);
    tick();
    chk("sim1_main_ok",   32'(bus.main_ok),   32'd1);
    chk("sim1_main_dout", 32'(bus.main_dout), 32'(init_val(13'h0010)));
    drop(1'b0);
    repeat (3) tick();
    chk("sim1_sub_ok_early", 32'(bus.sub_ok), 32'd0);
    tick();
    chk("sim1_sub_ok",   32'(bus.sub_ok),   32'd1);
    chk("sim1_sub_dout", 32'(bus.sub_dout), 32'h21);
    drop(1'b1);
    repeat (2) tick();
    req(1'b0, 1'b0, 13'h0030, 8'h00);
    req(1'b1, 1'b0, 13'h0020, 8'h00);
    repeat (3) tick();
    chk("sim2_sub_ok",  32'(bus.sub_ok),  32'd1);
    chk("sim2_main_ok", 32'(bus.main_ok), 32'd0);
    drop(1'b1);
    repeat (4) tick();
    chk("sim2_main_ok_late", 32'(bus.main_ok), 32'd1);
    drop(1'b0);
    repeat (2) tick();

    // Single main read with cs held high afterwards
    req(1'b0, 1'b0, 13'h0123, 8'h00);
    repeat (2) tick();
    chk("rd_ok_early", 32'(bus.main_ok), 32'd0);
    tick();
    chk("rd_ok",   32'(bus.main_ok),   32'd1);
    chk("rd_dout", 32'(bus.main_dout), 32'h5A);
    chk("rd_wait", 32'(bus.main_wait), 32'd0);
    okc = 0;
    repeat (8) begin
      tick();
      okc += int'(bus.main_ok) + int'(bus.ram_we);
    end
    chk("rd_held_no_reaccess", 32'(okc), 32'd0);
    drop(1'b0);
    tick();

    // Sub write then main read of the same address
    req(1'b1, 1'b1, 13'h1FFF, 8'hC3);
    tick();
    chk("wr_ram_we",   32'(bus.ram_we),   32'd1);
    chk("wr_ram_addr", 32'(bus.ram_addr), 32'h1FFF);
    chk("wr_ram_din",  32'(bus.ram_din),  32'hC3);
    tick();
    chk("wr_ram_we_off", 32'(bus.ram_we), 32'd0);
    tick();
    chk("wr_sub_ok", 32'(bus.sub_ok), 32'd1);
    drop(1'b1);
    tick();
    req(1'b0, 1'b0, 13'h1FFF, 8'h00);
    repeat (3) tick();
    chk("wr_main_ok",   32'(bus.main_ok),   32'd1);
    chk("wr_main_dout", 32'(bus.main_dout), 32'hC3);
    chk("wr_sub_dout",  32'(bus.sub_dout),  32'h21);
    drop(1'b0);
    tick();

    // cs dropped during ACC: access still completes, served stays clear
    req(1'b0, 1'b1, 13'h0042, 8'h99);
    tick();
    drop(1'b0);
    repeat (2) tick();
    chk("drop_ok", 32'(bus.main_ok), 32'd1);
    repeat (2) tick();
    chk("drop_mem", 32'(mem[13'h0042]), 32'h99);
    req(1'b0, 1'b0, 13'h0042, 8'h00);
    repeat (3) tick();
    chk("drop_fresh_ok",   32'(bus.main_ok),   32'd1);
    chk("drop_fresh_dout", 32'(bus.main_dout), 32'h99);
    drop(1'b0);
    tick();

    // Reset asserted during LAT
    req(1'b0, 1'b0, 13'h0100, 8'h00);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstlat_ram_we",    32'(bus.ram_we),    32'd0);
    chk("rstlat_main_ok",   32'(bus.main_ok),   32'd0);
    chk("rstlat_main_dout", 32'(bus.main_dout), 32'd0);
    chk("rstlat_sub_dout",  32'(bus.sub_dout),  32'd0);
    chk("rstlat_ram_addr",  32'(bus.ram_addr),  32'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("rstlat_ok_early", 32'(bus.main_ok), 32'd0);
    tick();
    chk("rstlat_ok",   32'(bus.main_ok),   32'd1);
    chk("rstlat_dout", 32'(bus.main_dout), 32'(init_val(13'h0100)));
    drop(1'b0);
    repeat (2) tick();

    // Continuous contention: both re-request right after each ok
    n_main = 0; n_sub = 0; prev = -1; breaks = 0;
    for (int c = 0; c < 1000 && (n_main + n_sub) < 100; c++) begin
      for (int p = 0; p < 2; p++) begin
        okp = (p == 1) ? bus.sub_ok : bus.main_ok;
        csp = (p == 1) ? bus.sub_cs : bus.main_cs;
        if (okp) begin
          if (p == prev) breaks++;
          prev = p;
          if (p == 1) n_sub++; else n_main++;
          drop(1'(p));
        end else if (!csp) begin
          req(1'(p), 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
        end
      end
      tick();
    end
    chk("cont_total",  32'(n_main + n_sub), 32'd100);
    chk("cont_main",   32'(n_main),         32'd50);
    chk("cont_sub",    32'(n_sub),          32'd50);
    chk("cont_breaks", 32'(breaks),         32'd0);
    drop(1'b0); drop(1'b1);
    repeat (6) tick();

    // Randomized traffic: late drops, held cs, post-request input changes
    done = 2'b00;
    repeat (3000) begin
      for (int p = 0; p < 2; p++) begin
        okp = (p == 1) ? bus.sub_ok : bus.main_ok;
        csp = (p == 1) ? bus.sub_cs : bus.main_cs;
        if (!csp) begin
          done[p] = 1'b0;
          if ($urandom_range(0, 2) == 0)
            req(1'(p), 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
        end else if (okp) begin
          done[p] = 1'b1;
          if ($urandom_range(0, 3) != 0) drop(1'(p));
        end else if (done[p]) begin
          if ($urandom_range(0, 1) == 0) drop(1'(p));
        end else begin
          okc = int'($urandom_range(0, 39));
          if (okc == 0) drop(1'(p));
          else if (okc < 5) scramble(1'(p));
        end
      end
      tick();
    end
    drop(1'b0); drop(1'b1);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
